// File: rtl/s3g_host_framer.sv
// S3G host framer: emits START_BYTE, length, payload and CRC-8/Maxim to a UART tx port, one byte per tx_done.
// Optional S3G_FRAMER_GAP_EN inserts GAP_CYCLES idle cycles after each tx_done before the next byte.
module s3g_host_framer #(
    parameter int         MAX_LEN    = 32,
    parameter logic [7:0] START_BYTE = 8'hD5
`ifdef S3G_FRAMER_GAP_EN
    ,
    parameter int         GAP_CYCLES = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_start,
    input  logic [7:0] pkt_len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    output logic       busy,
    output logic       pkt_done,
    output logic       pkt_err
);

    typedef enum logic [2:0] {IDLE, HDR, LEN, PL_GET, PL_SEND, CRC, WAIT, FIN} state_t;

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_t     state, state_nxt, ret;
    logic [7:0] len, remaining, crc;
    logic       len_ok, wait_adv;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        return r;
    endfunction

    assign len_ok = (pkt_len != 8'd0) && ({1'b0, pkt_len} <= MAX_LEN_W);

`ifdef S3G_FRAMER_GAP_EN
    logic        gapping;
    logic [15:0] gap_cnt;

    // The last byte's tx_done goes straight to FIN; all others sit out the gap first.
    assign wait_adv = (ret == FIN) ? tx_done : (gapping && gap_cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gapping <= 1'b0;
            gap_cnt <= 16'd0;
        end else if (state == WAIT && tx_done && !gapping && ret != FIN) begin
            gapping <= 1'b1;
            gap_cnt <= 16'(GAP_CYCLES);
        end else if (gapping) begin
            if (gap_cnt == 16'd0) gapping <= 1'b0;
            else                  gap_cnt <= gap_cnt - 16'd1;
        end
    end
`else
    assign wait_adv = tx_done;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pkt_start && len_ok) state_nxt = HDR;
            HDR,
            LEN,
            PL_SEND,
            CRC:     state_nxt = WAIT;
            PL_GET:  if (pl_valid) state_nxt = PL_SEND;
            WAIT:    if (wait_adv) state_nxt = ret;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx_data is loaded on the transition into each emitting state so tx_wr can follow directly from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data   <= 8'd0;
            len       <= 8'd0;
            remaining <= 8'd0;
            crc       <= 8'd0;
            ret       <= IDLE;
            pkt_err   <= 1'b0;
        end else begin
            pkt_err <= (state == IDLE) && pkt_start && !len_ok;
            unique case (state)
                IDLE: if (pkt_start && len_ok) begin
                    len       <= pkt_len;
                    remaining <= pkt_len;
                    crc       <= 8'd0;
                    tx_data   <= START_BYTE;
                end
                HDR:     ret <= LEN;
                LEN:     ret <= PL_GET;
                PL_GET: if (pl_valid) begin
                    tx_data   <= pl_data;
                    crc       <= crc8(crc, pl_data);
                    remaining <= remaining - 8'd1;
                end
                PL_SEND: ret <= (remaining != 8'd0) ? PL_GET : CRC;
                CRC:     ret <= FIN;
                WAIT: if (wait_adv) begin
                    if (ret == LEN)      tx_data <= len;
                    else if (ret == CRC) tx_data <= crc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_wr    = (state == HDR) || (state == LEN) || (state == PL_SEND) || (state == CRC);
        pl_ready = (state == PL_GET);
        busy     = (state != IDLE);
        pkt_done = (state == FIN);
    end

endmodule

// File: tb/tb_s3g_host_framer.sv
// Directed bench for s3g_host_framer: UART responder, payload source and bus monitor around a linear test sequence.
module tb_s3g_host_framer;

    localparam int MAX_LEN = 32;

    logic       clk = 1'b0;
    logic       rst, pkt_start, pl_valid, pl_ready, tx_wr, tx_done, busy, pkt_done, pkt_err;
    logic [7:0] pkt_len, pl_data, tx_data;

    int n_chk = 0, n_pass = 0;

    s3g_host_framer #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_len(pkt_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .busy(busy), .pkt_done(pkt_done), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    // Monitor: samples at posedge the values held through the cycle just ending.
    int         cyc = 0, n_wr = 0, n_done = 0, n_err = 0, n_xfer = 0, bad_ready = 0, dbl_wr = 0;
    logic [7:0] out_mem [0:1023];
    int         lat_mem [0:1023];
    int         wr_cyc  [0:1023];
    int         last_done = 0;
    bit         done_valid = 0, prev_wr = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            done_valid = 0;
            prev_wr    = 0;
        end else begin
            if (tx_wr) begin
                out_mem[n_wr] = tx_data;
                wr_cyc[n_wr]  = cyc;
                lat_mem[n_wr] = done_valid ? (cyc - last_done) : -1;
                n_wr++;
                if (prev_wr) dbl_wr++;
            end
            prev_wr = tx_wr;
            if (tx_done && !tx_wr) begin
                last_done  = cyc;
                done_valid = 1;
            end
            if (pkt_done) begin
                n_done++;
                done_valid = 0;
            end
            if (pkt_err) n_err++;
            if (pl_valid && pl_ready) n_xfer++;
            if (pl_ready && (tx_wr || !busy)) bad_ready++;
        end
    end

    // UART responder: tx_done 10 cycles after each tx_wr; optionally a bogus tx_done in the tx_wr cycle.
    bit inj_same = 0;
    initial begin
        int cnt;
        cnt = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) cnt = 0;
            else if (tx_wr) begin
                cnt = 10;
                if (inj_same) tx_done = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done = 1'b1;
            end
        end
    end

    // Payload source: presents pl_mem in order, with an optional one-time stall before byte stall_idx.
    logic [7:0] pl_mem [0:1023];
    int pl_total = 0, stall_idx = -1, stall_len = 0;
    initial begin
        int n_popped, stall_cnt, stall_served;
        n_popped = 0; stall_cnt = 0; stall_served = -1;
        pl_valid = 1'b0;
        pl_data  = 8'd0;
        forever begin
            @(negedge clk);
            while (n_popped < n_xfer) n_popped++;
            pl_valid = 1'b0;
            if (n_popped < pl_total) begin
                if (n_popped == stall_idx && stall_served != stall_idx && stall_cnt < stall_len)
                    stall_cnt++;
                else begin
                    if (n_popped == stall_idx) stall_served = stall_idx;
                    pl_valid = 1'b1;
                    pl_data  = pl_mem[n_popped];
                end
            end
        end
    end

    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 8'h8C;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic load(input logic [7:0] b);
        pl_mem[pl_total] = b;
        pl_total++;
    endtask

    task automatic start_pkt(input logic [7:0] len);
        @(negedge clk);
        pkt_len   = len;
        pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
    endtask

    task automatic wait_frame(input int target, input int budget, input string tag, output int idle_cyc);
        int k;
        k = 0;
        idle_cyc = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            if (!busy && n_done < target) idle_cyc++;
            k++;
        end
        chk(tag, 32'(n_done), 32'(target));
    endtask

    logic [7:0] exp_q[$];

    task automatic chk_frame(input int base, input string tag);
        chk({tag, "_nbytes"}, 32'(n_wr - base), 32'(exp_q.size()));
        foreach (exp_q[i])
            chk($sformatf("%s_b%0d", tag, i), 32'(out_mem[base + i]), 32'(exp_q[i]));
    endtask

    initial begin
        int base, idle, mx, mn, d0, e0, k;
        logic [7:0] c;
        rst = 1'b1; pkt_start = 1'b0; pkt_len = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl_outs", 32'({tx_wr, pl_ready, busy, pkt_done, pkt_err}), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single-byte frame
        base = n_wr;
        load(8'h01);
        start_pkt(8'd1);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        chk("t1_hdr_wr", 32'(tx_wr), 32'd1);
        wait_frame(1, 2000, "t1_pkt_done", idle);
        chk("t1_busy_held", 32'(idle), 32'd0);
        chk("t1_busy_low_after_fin", 32'(busy), 32'd0);
        exp_q = '{8'hD5, 8'h01, 8'h01, 8'h5E};
        chk_frame(base, "t1");
        mx = 0; mn = 1000;
        for (int i = 1; i < 4; i++) begin
            if (lat_mem[base + i] > mx) mx = lat_mem[base + i];
            if (lat_mem[base + i] < mn) mn = lat_mem[base + i];
        end
`ifdef S3G_FRAMER_GAP_EN
        chk("t1_gap_min_ge16", 32'(mn >= 16), 32'd1);
`else
        chk("t1_latency_le2", 32'(mx <= 2), 32'd1);
        chk("t1_latency_ge1", 32'(mn >= 1), 32'd1);
`endif

        // Two-byte frame with a 50-cycle payload stall before the second byte
        base = n_wr;
        stall_idx = pl_total + 1;
        stall_len = 50;
        load(8'h01); load(8'h02);
        start_pkt(8'd2);
        wait_frame(2, 3000, "t2_pkt_done", idle);
        exp_q = '{8'hD5, 8'h02, 8'h01, 8'h02, 8'h78};
        chk_frame(base, "t2");
        chk("t2_no_wr_in_stall", 32'((wr_cyc[base + 3] - wr_cyc[base + 2]) >= 50), 32'd1);
        chk("t2_ready_only_pl_get", 32'(bad_ready), 32'd0);

        // Rejected lengths
        base = n_wr; e0 = n_err;
        start_pkt(8'd0);
        chk("t3_err_len0", 32'(pkt_err), 32'd1);
        @(negedge clk);
        chk("t3_err_one_cycle", 32'(pkt_err), 32'd0);
        chk("t3_busy_len0", 32'(busy), 32'd0);
        start_pkt(8'(MAX_LEN + 1));
        chk("t3_err_len_over", 32'(pkt_err), 32'd1);
        chk("t3_busy_len_over", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("t3_err_count", 32'(n_err - e0), 32'd2);
        chk("t3_no_wr", 32'(n_wr - base), 32'd0);

        // Maximum-length frame, with bogus tx_done pulses in every tx_wr cycle
        inj_same = 1;
        c = 8'h00;
        exp_q = '{8'hD5, 8'(MAX_LEN)};
        for (int i = 0; i < MAX_LEN; i++) begin
            load(8'(i));
            exp_q.push_back(8'(i));
            c = ref_crc(c, 8'(i));
        end
        exp_q.push_back(c);
        start_pkt(8'(MAX_LEN));
        wait_frame(3, 5000, "t3_pkt_done", idle);
        chk_frame(base, "t3");
        inj_same = 0;

        // pkt_start while busy is ignored
        base = n_wr; e0 = n_err; d0 = n_done;
        load(8'hAA); load(8'h55);
        start_pkt(8'd2);
        repeat (5) @(negedge clk);
        start_pkt(8'd5);
        start_pkt(8'd0);
        wait_frame(d0 + 1, 3000, "t4_pkt_done", idle);
        repeat (40) @(negedge clk);
        exp_q = '{8'hD5, 8'h02, 8'hAA, 8'h55, ref_crc(ref_crc(8'h00, 8'hAA), 8'h55)};
        chk_frame(base, "t4");
        chk("t4_no_err_while_busy", 32'(n_err - e0), 32'd0);
        chk("t4_one_frame", 32'(n_done - d0), 32'd1);
        chk("t4_idle_after", 32'(busy), 32'd0);

        // Asynchronous reset after the LEN byte
        base = n_wr;
        start_pkt(8'd3);
        k = 0;
        while (n_wr < base + 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("t5_len_sent", 32'(n_wr - base), 32'd2);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_ctrl_outs", 32'({tx_wr, pl_ready, busy, pkt_done, pkt_err}), 32'd0);
        chk("t5_async_tx_data", 32'(tx_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (30) @(negedge clk);
        chk("t5_no_wr_after_rst", 32'(n_wr - base), 32'd2);
        base = n_wr;
        load(8'h02);
        start_pkt(8'd1);
        wait_frame(d0 + 1, 2000, "t5_pkt_done", idle);
        exp_q = '{8'hD5, 8'h01, 8'h02, 8'hBC};
        chk_frame(base, "t5");

        chk("never_back_to_back_wr", 32'(dbl_wr), 32'd0);
        chk("ready_only_in_frame", 32'(bad_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
